// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO feeding a UART transmitter: buffers bus writes and
// hands them over one at a time with a single-cycle write strobe, pacing on busy.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic [7:0]            push_data_i,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  overflow_o,
    output logic [7:0]            uart_data_o,
    output logic                  uart_write_o,
    input  logic                  uart_busy_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] STROBE    = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic [1:0]            state;
    logic                  do_push;
    logic                  do_pop;

    // Full is judged on the pre-edge count; a flush cancels both a push and a new pop.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = (state == IDLE) && !empty_o && !uart_busy_i && !flush_i;
    assign level_o = count;

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + CNT_ONE;
        else if (!do_push && do_pop)
            count_next = count - CNT_ONE;
    end

    always_ff @(posedge clock_i) begin
        if (do_push)
            mem[wr_ptr] <= push_data_i;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full_o       <= 1'b0;
            empty_o      <= 1'b1;
            overflow_o   <= 1'b0;
            state        <= IDLE;
            uart_write_o <= 1'b0;
            uart_data_o  <= 8'h00;
        end else begin
            if (flush_i) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                full_o     <= 1'b0;
                empty_o    <= 1'b1;
                overflow_o <= 1'b0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (do_pop)
                    rd_ptr <= rd_ptr + PTR_ONE;
                if (push_i && full_o)
                    overflow_o <= 1'b1;
                count   <= count_next;
                full_o  <= (count_next == CNT_FULL);
                empty_o <= (count_next == '0);
            end

            // A byte already handed over keeps running through the busy handshake even across a flush.
            case (state)
                IDLE: begin
                    if (do_pop) begin
                        uart_data_o  <= mem[rd_ptr];
                        uart_write_o <= 1'b1;
                        state        <= STROBE;
                    end
                end
                STROBE: begin
                    uart_write_o <= 1'b0;
                    state        <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (uart_busy_i)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!uart_busy_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
